ctrl_escrita_banco: RTL and testbench
=====================================

# ctrl_escrita_banco

Write-back controller driving the single write port of the 4×32-bit register bank. It buffers results from the execute/memory stages in a small FIFO and issues at most one bank write per cycle. It keeps a per-register outstanding-write scoreboard for the issue stage, and forwards still-unwritten results to the bank's two read addresses.

## Interface
- LARGURA, 32, data width of a register
- N_REG_BITS, 2, register address width (4 registers)
- PROF, 4, result FIFO depth; power of two, ≥2
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- res_valid  in  1  result offered
- res_ready  out  1  result accepted this cycle when res_valid && res_ready
- res_reg  in  N_REG_BITS  destination register of result
- res_dado  in  LARGURA  result value
- reg_e  out  N_REG_BITS  bank write address (registered)
- e_l  out  1  bank write strobe, 1 = write (registered)
- dado  out  LARGURA  bank write data (registered)
- aloc  in  1  issue stage reserves a destination register this cycle
- aloc_reg  in  N_REG_BITS  register being reserved
- pend  out  2**N_REG_BITS  bit r = register r has outstanding writes
- fnt1, fnt2  in  N_REG_BITS  bank read addresses, mirrored for forwarding
- fwd1_ok, fwd2_ok  out  1  a newer value for fntX exists in this block
- fwd1_dado, fwd2_dado  out  LARGURA  that value
- erro  out  1  sticky scoreboard overflow/underflow flag

## Operation
- Reset: FIFO empty, e_l=0, reg_e=0, dado=0, all counters 0, pend=0, erro=0. While rst=1: res_ready=0, fwd*_ok=0. Reset mid-stream discards all buffered results.
- res_ready = !rst && !full (combinational). No push when full, even if a pop occurs the same edge.
- Push: on edge with res_valid && res_ready, {res_reg, res_dado} enters FIFO tail.
- Issue: each edge, if FIFO non-empty, head is popped into the output register: e_l<=1, reg_e<=head.reg, dado<=head.dado; else e_l<=0, reg_e/dado hold. Push and pop in the same edge allowed at any non-full level, including empty→one-in-one-out is not allowed (an entry must be in the FIFO before it can pop).
- Scoreboard: one counter per register, width clog2(PROF+4). aloc increments cnt[aloc_reg]; an issue (pop) of register r decrements cnt[r]. Same-edge aloc and issue of the same register: unchanged. pend[r] = (cnt[r] != 0).
- Error: aloc at counter maximum → counter holds, erro<=1. Issue of r with cnt[r]==0 → counter holds at 0, erro<=1. erro clears only on rst.
- Forwarding (combinational, per port X): search FIFO entries for reg==fntX; the youngest match wins. Else, if e_l=1 and reg_e==fntX, forward dado, because the bank has not yet committed that write. Else fwdX_ok=0 and fwdX_dado=0.

## Timing
- Latency: result pushed at edge k appears on the bank port (e_l=1) in the cycle after edge k+1. The bank commits it at edge k+2.
- Throughput: one write per cycle sustained; FIFO occupancy steady at 1 under continuous push.
- pend reflects aloc one edge after the aloc cycle. pend drops at the edge that loads the last outstanding write into the output register.
- Forwarding outputs follow fnt1/fnt2 in the same cycle; no registered stage.
- Wrap-around: FIFO pointers are N_REG-independent, log2(PROF)+1 bits, with full/empty from the MSB comparison.

## Structure
- Package banco_pkg: LARGURA, N_REG_BITS, N_REG=2**N_REG_BITS, typedef entrada_t {reg, dado}. Shared with the bank.
- Sub-module fifo_sinc (parameterised depth/type, sync reset) holds the entries. It exposes all slots plus valid bits for the forwarding search.
- Scoreboard counters, output register and forward mux live in the top module.

## Test plan
- Reset with res_valid=1: res_ready=0, e_l=0, pend=0. After release, push r2=0xDEADBEEF at edge k → e_l=1, reg_e=2, dado=0xDEADBEEF after edge k+1, e_l=0 after k+2.
- Hold ready low externally by stalling pops is impossible, so fill test: push 5 results in consecutive cycles to PROF=4. Writes come out in order at one per cycle, and res_ready never drops (steady occupancy ≤2).
- Forwarding: push r1=0x11 then r1=0x22 back-to-back with fnt1=1 → fwd1_ok=1, fwd1_dado=0x22 while both are present. Then 0x22 comes from the output register during its write cycle, then fwd1_ok=0.
- Scoreboard: aloc r3 twice → pend[3]=1. First r3 write issue → still 1. Second → pend[3]=0. Same-edge aloc r3 and issue r3 → pend[3] unchanged.
- Error: issue r0 with no aloc → erro=1, cnt[0] stays 0, erro persists until rst.
- Reset with 3 entries buffered: next cycle e_l=0, FIFO empty, pend=0, no stale write appears afterwards.

Source files
------------

// File: rtl/banco_pkg.sv
// Shared definitions for the 4x32-bit register bank and its write-back controller.
//   LARGURA    : register data width
//   N_REG_BITS : register address width
//   N_REG      : number of registers
//   entrada_t  : one buffered write-back result {destination register, value}
package banco_pkg;

    localparam int unsigned LARGURA    = 32;
    localparam int unsigned N_REG_BITS = 2;
    localparam int unsigned N_REG      = 2 ** N_REG_BITS;

    typedef struct packed {
        logic [N_REG_BITS-1:0] registro;
        logic [LARGURA-1:0]    dado;
    } entrada_t;

endpackage

// File: rtl/fifo_sinc.sv
// Synchronous FIFO with all storage slots exposed for associative searches.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push_i     : write dado_i at the tail (ignored when full)
//   pop_i      : drop the head entry (ignored when empty)
//   cabeca_o   : head entry
//   vazio_o    : FIFO empty
//   cheio_o    : FIFO full
//   ini_o      : physical slot index of the head (oldest entry)
//   slots_o    : raw storage, indexed by physical slot
//   valido_o   : bit s = physical slot s holds a live entry
module fifo_sinc #(
    parameter int unsigned Prof = 4,
    parameter type         T    = logic
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  T                        dado_i,
    input  logic                    pop_i,
    output T                        cabeca_o,
    output logic                    vazio_o,
    output logic                    cheio_o,
    output logic [$clog2(Prof)-1:0] ini_o,
    output T     [Prof-1:0]         slots_o,
    output logic [Prof-1:0]         valido_o
);

    localparam int unsigned IdxW = $clog2(Prof);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [IdxW:0]   esc_q, esc_d, lei_q, lei_d;
    logic [IdxW:0]   ocup;
    logic [IdxW-1:0] offs;
    logic            faz_push, faz_pop;
    T [Prof-1:0]     mem_q;

    assign vazio_o  = (esc_q == lei_q);
    assign cheio_o  = (esc_q[IdxW] != lei_q[IdxW]) && (esc_q[IdxW-1:0] == lei_q[IdxW-1:0]);
    assign faz_push = push_i && !cheio_o;
    assign faz_pop  = pop_i && !vazio_o;
    assign esc_d    = faz_push ? esc_q + 1'b1 : esc_q;
    assign lei_d    = faz_pop ? lei_q + 1'b1 : lei_q;
    assign cabeca_o = mem_q[lei_q[IdxW-1:0]];
    assign ini_o    = lei_q[IdxW-1:0];
    assign slots_o  = mem_q;
    assign ocup     = esc_q - lei_q;

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        offs     = '0;
        valido_o = '0;
        for (int s = 0; s < int'(Prof); s++) begin
            offs        = IdxW'(s) - lei_q[IdxW-1:0];
            valido_o[s] = ({1'b0, offs} < ocup);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            esc_q <= '0;
            lei_q <= '0;
        end else begin
            esc_q <= esc_d;
            lei_q <= lei_d;
        end
    end

    // Storage needs no reset: the live bits gate every use of it.
    always_ff @(posedge clk) begin
        if (faz_push) begin
            mem_q[esc_q[IdxW-1:0]] <= dado_i;
        end
    end

endmodule

// File: rtl/ctrl_escrita_banco.sv
// Write-back controller for the single write port of the register bank.
// Buffers results in a FIFO, issues one bank write per cycle, tracks outstanding
// writes per register and forwards not-yet-committed values to the two read ports.
//   clk, rst              : clock, synchronous active-high reset
//   res_valid/res_ready   : result handshake; res_reg/res_dado carry the result
//   reg_e, e_l, dado      : registered bank write port
//   aloc, aloc_reg        : issue stage reserves a destination register
//   pend                  : bit r = register r has outstanding writes
//   fnt1, fnt2            : bank read addresses mirrored for forwarding
//   fwdX_ok, fwdX_dado    : newer value for fntX held in this block
//   erro                  : sticky scoreboard overflow/underflow
// Data and address widths come from banco_pkg so they always match the bank.
module ctrl_escrita_banco
    import banco_pkg::*;
#(
    parameter int unsigned PROF = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  res_valid,
    output logic                  res_ready,
    input  logic [N_REG_BITS-1:0] res_reg,
    input  logic [LARGURA-1:0]    res_dado,
    output logic [N_REG_BITS-1:0] reg_e,
    output logic                  e_l,
    output logic [LARGURA-1:0]    dado,
    input  logic                  aloc,
    input  logic [N_REG_BITS-1:0] aloc_reg,
    output logic [N_REG-1:0]      pend,
    input  logic [N_REG_BITS-1:0] fnt1,
    input  logic [N_REG_BITS-1:0] fnt2,
    output logic                  fwd1_ok,
    output logic [LARGURA-1:0]    fwd1_dado,
    output logic                  fwd2_ok,
    output logic [LARGURA-1:0]    fwd2_dado,
    output logic                  erro
);

    localparam int unsigned IdxW = $clog2(PROF);
    localparam int unsigned CntW = $clog2(PROF + 4);
    localparam logic [CntW-1:0] CntMax = '1;

    logic                  cheio, vazio, push, pop;
    entrada_t              cabeca, entrada;
    entrada_t [PROF-1:0]   slots;
    logic     [PROF-1:0]   valido;
    logic     [IdxW-1:0]   ini, idx;

    logic                  e_l_q;
    logic [N_REG_BITS-1:0] reg_e_q;
    logic [LARGURA-1:0]    dado_q;

    logic [N_REG-1:0][CntW-1:0] cnt_q, cnt_d;
    logic                       erro_q, erro_d;
    logic                       inc, dec;

    assign res_ready = !rst && !cheio;
    assign push      = res_valid && res_ready;
    assign pop       = !vazio;
    assign entrada   = '{registro: res_reg, dado: res_dado};

    fifo_sinc #(
        .Prof (PROF),
        .T    (entrada_t)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_i   (push),
        .dado_i   (entrada),
        .pop_i    (pop),
        .cabeca_o (cabeca),
        .vazio_o  (vazio),
        .cheio_o  (cheio),
        .ini_o    (ini),
        .slots_o  (slots),
        .valido_o (valido)
    );

    // Output register: the popped head drives the bank write port for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_l_q   <= 1'b0;
            reg_e_q <= '0;
            dado_q  <= '0;
        end else begin
            e_l_q <= pop;
            if (pop) begin
                reg_e_q <= cabeca.registro;
                dado_q  <= cabeca.dado;
            end
        end
    end

    assign e_l   = e_l_q;
    assign reg_e = reg_e_q;
    assign dado  = dado_q;

    // Scoreboard: a reservation and an issue of the same register cancel out.
    always_comb begin
        cnt_d  = cnt_q;
        erro_d = erro_q;
        inc    = 1'b0;
        dec    = 1'b0;
        for (int r = 0; r < int'(N_REG); r++) begin
            inc = aloc && (aloc_reg == N_REG_BITS'(r));
            dec = pop && (cabeca.registro == N_REG_BITS'(r));
            if (inc && !dec) begin
                if (cnt_q[r] == CntMax) erro_d = 1'b1;
                else                    cnt_d[r] = cnt_q[r] + 1'b1;
            end else if (dec && !inc) begin
                if (cnt_q[r] == '0) erro_d = 1'b1;
                else                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            erro_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            erro_q <= erro_d;
        end
    end

    always_comb begin
        pend = '0;
        for (int r = 0; r < int'(N_REG); r++) begin
            pend[r] = (cnt_q[r] != '0);
        end
    end

    assign erro = erro_q;

    // Forwarding: the output register is the oldest candidate, then FIFO entries
    // from head to tail, so the last match found is the youngest value.
    always_comb begin
        fwd1_ok   = 1'b0;
        fwd1_dado = '0;
        fwd2_ok   = 1'b0;
        fwd2_dado = '0;
        idx       = '0;
        if (!rst) begin
            if (e_l_q && (reg_e_q == fnt1)) begin
                fwd1_ok   = 1'b1;
                fwd1_dado = dado_q;
            end
            if (e_l_q && (reg_e_q == fnt2)) begin
                fwd2_ok   = 1'b1;
                fwd2_dado = dado_q;
            end
            for (int k = 0; k < int'(PROF); k++) begin
                idx = ini + IdxW'(k);
                if (valido[idx] && (slots[idx].registro == fnt1)) begin
                    fwd1_ok   = 1'b1;
                    fwd1_dado = slots[idx].dado;
                end
                if (valido[idx] && (slots[idx].registro == fnt2)) begin
                    fwd2_ok   = 1'b1;
                    fwd2_dado = slots[idx].dado;
                end
            end
        end
    end

endmodule

// File: tb/tb_ctrl_escrita_banco.sv
// Self-checking bench for ctrl_escrita_banco: directed scenarios with literal
// expectations followed by random traffic, all compared every cycle against a
// queue-based model of the write-back behaviour.
module tb_ctrl_escrita_banco;
    import banco_pkg::*;

    localparam int PROF   = 4;
    localparam int CNTMAX = (2 ** $clog2(PROF + 4)) - 1;

    logic                  clk = 1'b0;
    logic                  rst, res_valid, res_ready, e_l, aloc, erro;
    logic [N_REG_BITS-1:0] res_reg, reg_e, aloc_reg, fnt1, fnt2;
    logic [LARGURA-1:0]    res_dado, dado, fwd1_dado, fwd2_dado;
    logic [N_REG-1:0]      pend;
    logic                  fwd1_ok, fwd2_ok;

    int total  = 0;
    int passes = 0;

    // Behavioural model state
    int          q_reg[$];
    logic [31:0] q_dado[$];
    int          m_cnt[N_REG];
    logic        m_el, m_erro;
    logic [1:0]  m_reg;
    logic [31:0] m_dado;

    always #5 clk = ~clk;

    ctrl_escrita_banco #(.PROF(PROF)) dut (
        .clk       (clk),
        .rst       (rst),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_reg   (res_reg),
        .res_dado  (res_dado),
        .reg_e     (reg_e),
        .e_l       (e_l),
        .dado      (dado),
        .aloc      (aloc),
        .aloc_reg  (aloc_reg),
        .pend      (pend),
        .fnt1      (fnt1),
        .fnt2      (fnt2),
        .fwd1_ok   (fwd1_ok),
        .fwd1_dado (fwd1_dado),
        .fwd2_ok   (fwd2_ok),
        .fwd2_dado (fwd2_dado),
        .erro      (erro)
    );

    task automatic chk(input string nome, input logic [63:0] obtido, input logic [63:0] esperado);
        total++;
        if (obtido === esperado) passes++;
        else $display("FAIL %s at %0t: got %h, expected %h", nome, $time, obtido, esperado);
    endtask

    task automatic modelo_reset();
        q_reg.delete();
        q_dado.delete();
        foreach (m_cnt[r]) m_cnt[r] = 0;
        m_el   = 1'b0;
        m_erro = 1'b0;
        m_reg  = '0;
        m_dado = '0;
    endtask

    task automatic modelo_fwd(input logic [1:0] f, output logic ok, output logic [31:0] d);
        ok = 1'b0;
        d  = '0;
        if (rst) return;
        for (int i = q_reg.size() - 1; i >= 0; i--) begin
            if (q_reg[i] == int'(f)) begin
                ok = 1'b1;
                d  = q_dado[i];
                return;
            end
        end
        if (m_el && m_reg == f) begin
            ok = 1'b1;
            d  = m_dado;
        end
    endtask

    task automatic comparar();
        logic        ok;
        logic [31:0] d;
        logic [3:0]  p;
        chk("res_ready", 64'(res_ready), 64'(!rst && q_reg.size() < PROF));
        chk("e_l", 64'(e_l), 64'(m_el));
        chk("reg_e", 64'(reg_e), 64'(m_reg));
        chk("dado", 64'(dado), 64'(m_dado));
        chk("erro", 64'(erro), 64'(m_erro));
        for (int r = 0; r < N_REG; r++) p[r] = (m_cnt[r] != 0);
        chk("pend", 64'(pend), 64'(p));
        modelo_fwd(fnt1, ok, d);
        chk("fwd1_ok", 64'(fwd1_ok), 64'(ok));
        chk("fwd1_dado", 64'(fwd1_dado), 64'(d));
        modelo_fwd(fnt2, ok, d);
        chk("fwd2_ok", 64'(fwd2_ok), 64'(ok));
        chk("fwd2_dado", 64'(fwd2_dado), 64'(d));
    endtask

    // Model update for one rising edge, from the inputs held across it.
    task automatic atualizar();
        bit cheio, tira;
        int reg_tirado, delta;
        if (rst) begin
            modelo_reset();
            return;
        end
        cheio      = (q_reg.size() >= PROF);
        tira       = (q_reg.size() > 0);
        reg_tirado = -1;
        if (tira) begin
            reg_tirado = q_reg[0];
            m_el       = 1'b1;
            m_reg      = 2'(q_reg[0]);
            m_dado     = q_dado[0];
            void'(q_reg.pop_front());
            void'(q_dado.pop_front());
        end else begin
            m_el = 1'b0;
        end
        if (res_valid && !cheio) begin
            q_reg.push_back(int'(res_reg));
            q_dado.push_back(res_dado);
        end
        for (int r = 0; r < N_REG; r++) begin
            delta = ((aloc && int'(aloc_reg) == r) ? 1 : 0) - ((reg_tirado == r) ? 1 : 0);
            if (delta > 0) begin
                if (m_cnt[r] == CNTMAX) m_erro = 1'b1;
                else m_cnt[r]++;
            end else if (delta < 0) begin
                if (m_cnt[r] == 0) m_erro = 1'b1;
                else m_cnt[r]--;
            end
        end
    endtask

    // One cycle: drive at the falling edge, check, let the rising edge happen.
    task automatic passo(input logic r, input logic v, input logic [1:0] rr, input logic [31:0] rd,
                         input logic a, input logic [1:0] ar, input logic [1:0] f1,
                         input logic [1:0] f2);
        rst       = r;
        res_valid = v;
        res_reg   = rr;
        res_dado  = rd;
        aloc      = a;
        aloc_reg  = ar;
        fnt1      = f1;
        fnt2      = f2;
        #1;
        comparar();
        @(posedge clk);
        atualizar();
        @(negedge clk);
    endtask

    task automatic ocioso(input logic [1:0] f1);
        passo(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, f1, 2'd0);
    endtask

    initial begin
        rst = 1'b1; res_valid = 1'b1; res_reg = '0; res_dado = '0;
        aloc = 1'b0; aloc_reg = '0; fnt1 = '0; fnt2 = '0;
        modelo_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset held with a result offered
        passo(1'b1, 1'b1, 2'd1, 32'h1234, 1'b0, 2'd0, 2'd1, 2'd1);
        chk("rst_ready", 64'(res_ready), 64'd0);
        chk("rst_e_l", 64'(e_l), 64'd0);
        chk("rst_pend", 64'(pend), 64'd0);

        // Single write latency
        passo(1'b0, 1'b1, 2'd2, 32'hDEADBEEF, 1'b0, 2'd0, 2'd0, 2'd0);
        ocioso(2'd0);
        chk("lat_e_l", 64'(e_l), 64'd1);
        chk("lat_reg_e", 64'(reg_e), 64'd2);
        chk("lat_dado", 64'(dado), 64'hDEADBEEF);
        ocioso(2'd0);
        chk("lat_e_l_off", 64'(e_l), 64'd0);

        // Back-to-back pushes: in order, one per cycle, never stalled
        for (int i = 0; i < 5; i++) begin
            passo(1'b0, 1'b1, 2'(i), 32'h100 + 32'(i), 1'b0, 2'd0, 2'd0, 2'd0);
            chk("fill_ready", 64'(res_ready), 64'd1);
            if (i >= 1) chk("fill_dado", 64'(dado), 64'h100 + 64'(i - 1));
        end
        ocioso(2'd0);
        chk("fill_last", 64'(dado), 64'h104);

        // Forwarding: youngest buffered value wins, then the output register
        passo(1'b0, 1'b1, 2'd1, 32'h11, 1'b0, 2'd0, 2'd1, 2'd0);
        passo(1'b0, 1'b1, 2'd1, 32'h22, 1'b0, 2'd0, 2'd1, 2'd0);
        chk("fwd_both_ok", 64'(fwd1_ok), 64'd1);
        chk("fwd_both_dado", 64'(fwd1_dado), 64'h22);
        ocioso(2'd1);
        chk("fwd_out_ok", 64'(fwd1_ok), 64'd1);
        chk("fwd_out_dado", 64'(fwd1_dado), 64'h22);
        ocioso(2'd1);
        chk("fwd_gone", 64'(fwd1_ok), 64'd0);

        // Scoreboard on r3
        passo(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 2'd3, 2'd0, 2'd0);
        passo(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 2'd3, 2'd0, 2'd0);
        chk("sb_two", 64'(pend[3]), 64'd1);
        passo(1'b0, 1'b1, 2'd3, 32'hA, 1'b0, 2'd0, 2'd0, 2'd0);
        passo(1'b0, 1'b1, 2'd3, 32'hB, 1'b0, 2'd0, 2'd0, 2'd0);
        chk("sb_first_issue", 64'(pend[3]), 64'd1);
        ocioso(2'd0);
        chk("sb_second_issue", 64'(pend[3]), 64'd0);
        passo(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 2'd3, 2'd0, 2'd0);
        passo(1'b0, 1'b1, 2'd3, 32'hC, 1'b0, 2'd0, 2'd0, 2'd0);
        passo(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 2'd3, 2'd0, 2'd0);
        chk("sb_same_edge", 64'(pend[3]), 64'd1);

        // Underflow is sticky until reset
        passo(1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 2'd0, 2'd0);
        chk("err_clear", 64'(erro), 64'd0);
        passo(1'b0, 1'b1, 2'd0, 32'h5, 1'b0, 2'd0, 2'd0, 2'd0);
        ocioso(2'd0);
        chk("err_set", 64'(erro), 64'd1);
        chk("err_cnt0", 64'(pend[0]), 64'd0);
        repeat (3) ocioso(2'd0);
        chk("err_sticky", 64'(erro), 64'd1);
        passo(1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 2'd0, 2'd0);
        chk("err_rst", 64'(erro), 64'd0);

        // Reset mid-stream discards buffered work
        passo(1'b0, 1'b1, 2'd1, 32'h1, 1'b1, 2'd1, 2'd0, 2'd0);
        passo(1'b0, 1'b1, 2'd2, 32'h2, 1'b1, 2'd1, 2'd0, 2'd0);
        passo(1'b0, 1'b1, 2'd3, 32'h3, 1'b1, 2'd2, 2'd3, 2'd0);
        passo(1'b1, 1'b1, 2'd3, 32'h4, 1'b0, 2'd0, 2'd3, 2'd0);
        chk("mid_rst_e_l", 64'(e_l), 64'd0);
        chk("mid_rst_pend", 64'(pend), 64'd0);
        ocioso(2'd3);
        chk("mid_rst_stale", 64'(e_l), 64'd0);
        chk("mid_rst_fwd", 64'(fwd1_ok), 64'd0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            passo(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                  2'($urandom_range(0, 3)), $urandom(),
                  ($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0,
                  2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
